// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_pkg
// Description : Shared types and helpers for the adder tree front end.
//               - loader_state_t : FILL/HOLD state of the frame loader
//               - lane_live()    : lane-vector helper used for zero-fill
// Revision    : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } loader_state_t;

  localparam int DEF_DATA_W = 5;
  localparam int DEF_DATA_N = 11;

  // A lane carries a real sample only when it sits below the frame count;
  // every other lane is forced to zero, the adder identity.
  function automatic logic lane_live(input int lane, input int cnt);
    return (lane < cnt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree_loader.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_loader
// Description : Collects a serial valid/ready sample stream into frames of
//               DATA_N lanes and presents each frame as a registered parallel
//               vector. Double-buffered: the next frame fills while the
//               current one is held. Short frames are zero-padded.
// Ports       : clk, rst_n          - clock, async active-low reset
//               s_data/s_valid/s_last/s_ready - serial sample input
//               o_data  [0:N-1][W-1:0] - frame, lane 0 = first sample
//               o_cnt               - number of real lanes, 1..DATA_N
//               o_valid/o_ready     - frame handshake
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DATA_N = DEF_DATA_N,
  localparam int CNT_W  = $clog2(DATA_N + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [0:DATA_N-1][DATA_W-1:0]  o_data,
  output logic [CNT_W-1:0]               o_cnt,
  output logic                           o_valid,
  input  logic                           o_ready
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_N - 1);

  loader_state_t                   state_q;
  logic [CNT_W-1:0]                idx_q;
  logic [0:DATA_N-1][DATA_W-1:0]   col_q;
  logic [0:DATA_N-1][DATA_W-1:0]   o_data_q;
  logic [CNT_W-1:0]                o_cnt_q;
  logic                            o_valid_q;

  logic                            accept;
  logic                            frame_done;
  logic                            slot_free;
  logic                            hold_exit;
  logic                            direct_load;
  logic [CNT_W-1:0]                idx_inc;
  logic [CNT_W-1:0]                cnt_d;
  logic [0:DATA_N-1][DATA_W-1:0]   col_merged;
  logic [0:DATA_N-1][DATA_W-1:0]   frame_d;

  // s_ready depends on state only, so there is no combinational path from
  // s_valid or o_ready back to the producer.
  assign s_ready     = (state_q == ST_FILL);
  assign accept      = s_valid & s_ready;
  assign frame_done  = accept & ((idx_q == LAST_IDX) | s_last);
  assign slot_free   = ~o_valid_q | o_ready;
  // In HOLD the slot is always occupied, so o_ready alone frees it.
  assign hold_exit   = (state_q == ST_HOLD) & o_ready;
  assign direct_load = frame_done & slot_free;

  always_comb begin
    col_merged = col_q;
    for (int l = 0; l < DATA_N; l++) begin
      if (accept && (idx_q == CNT_W'(l))) begin
        col_merged[l] = s_data;
      end
    end

    idx_inc = idx_q + CNT_W'(1);
    // In HOLD, idx_q already holds the stored frame count.
    cnt_d   = hold_exit ? idx_q : idx_inc;

    for (int l = 0; l < DATA_N; l++) begin
      frame_d[l] = lane_live(l, int'(cnt_d)) ? (hold_exit ? col_q[l] : col_merged[l])
                                             : '0;
    end
  end

  // Collection side: state, write index and collection buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (frame_done && slot_free) begin
              col_q <= '0;
              idx_q <= '0;
            end else begin
              col_q <= col_merged;
              idx_q <= idx_inc;
              if (frame_done) begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (o_ready) begin
            col_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Output slot: loads either straight from the closing sample or from the
  // completed frame parked in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data_q  <= '0;
      o_cnt_q   <= '0;
      o_valid_q <= 1'b0;
    end else if (hold_exit || direct_load) begin
      o_data_q  <= frame_d;
      o_cnt_q   <= cnt_d;
      o_valid_q <= 1'b1;
    end else if (o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign o_data  = o_data_q;
  assign o_cnt   = o_cnt_q;
  assign o_valid = o_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree_loader
// Description : Scoreboard bench for adder_tree_loader (DATA_W=5, DATA_N=11).
//               Stimulus pushes hand-computed frames; a negedge monitor pops
//               and compares on every o_valid & o_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_tree_loader;

  localparam int DW = 5;
  localparam int DN = 11;
  localparam int CW = 4;

  typedef logic [0:DN-1][DW-1:0] frame_t;
  typedef struct {
    frame_t     lanes;
    logic [CW-1:0] cnt;
    int         sum;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  frame_t          o_data;
  logic [CW-1:0]   o_cnt;
  logic            o_valid;
  logic            o_ready = 1'b0;

  exp_t   exp_q[$];
  int     pop_cyc[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     stalls = 0;
  logic   prev_hold = 1'b0;
  frame_t prev_data;
  logic [CW-1:0] prev_cnt;

  adder_tree_loader #(.DATA_W(DW), .DATA_N(DN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .o_data (o_data),
    .o_cnt  (o_cnt),
    .o_valid(o_valid),
    .o_ready(o_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lane_sum(input frame_t f);
    int s = 0;
    for (int l = 0; l < DN; l++) s += int'(f[l]);
    return s;
  endfunction

  task automatic push_exp(input frame_t lanes, input int cnt, input int sum);
    exp_t e;
    e.lanes = lanes;
    e.cnt   = CW'(cnt);
    e.sum   = sum;
    exp_q.push_back(e);
  endtask

  // Offer one sample; returns at posedge+1 after it is accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    logic acc;
    int   guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (guard > 1) stalls += guard - 1;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on transfer, stability check while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else if (o_valid && o_ready) begin
      prev_hold = 1'b0;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(o_cnt), 64'hFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_lanes", 64'(o_data), 64'(e.lanes));
        check("frame_cnt",   64'(o_cnt),  64'(e.cnt));
        check("tree_sum",    64'(lane_sum(o_data)), 64'(e.sum));
      end
    end else if (o_valid) begin
      if (prev_hold) begin
        check("hold_data", 64'(o_data), 64'(prev_data));
        check("hold_cnt",  64'(o_cnt),  64'(prev_cnt));
      end
      prev_hold = 1'b1;
      prev_data = o_data;
      prev_cnt  = o_cnt;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    frame_t f;
    int guard;

    // Reset state
    #12;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_cnt",   64'(o_cnt),   64'd0);
    check("rst_o_data",  64'(o_data),  64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: samples 1..11, o_ready=1; tree sum 66
    o_ready = 1'b1;
    for (int i = 0; i < DN; i++) f[i] = DW'(i + 1);
    push_exp(f, 11, 66);
    for (int i = 1; i <= 10; i++) send(DW'(i), 1'b0);
    check("t1_valid_before_last", 64'(o_valid), 64'd0);
    send(DW'(11), 1'b0);
    check("t1_valid_after_last", 64'(o_valid), 64'd1);
    idle(3);
    check("t1_valid_drop", 64'(o_valid), 64'd0);

    // 2: short frame of four 31s
    f = '0;
    for (int i = 0; i < 4; i++) f[i] = 5'd31;
    push_exp(f, 4, 124);
    for (int i = 0; i < 4; i++) send(5'd31, i == 3);
    idle(3);

    // 3: backpressure, 22 samples; frame 1 = 1..11, frame 2 = 20..30
    o_ready = 1'b0;
    for (int i = 0; i < DN; i++) f[i] = DW'(i + 1);
    push_exp(f, 11, 66);
    for (int i = 0; i < DN; i++) f[i] = DW'(i + 20);
    push_exp(f, 11, 275);
    for (int i = 1; i <= 11; i++) send(DW'(i), 1'b0);
    for (int i = 20; i <= 30; i++) send(DW'(i), 1'b0);
    check("t3_sready_low", 64'(s_ready), 64'd0);
    s_valid = 1'b1;
    s_data  = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    check("t3_sready_back", 64'(s_ready), 64'd1);
    check("t3_frame2_valid", 64'(o_valid), 64'd1);
    idle(3);
    o_ready = 1'b1;
    idle(1);
    check("t3_valid_drop", 64'(o_valid), 64'd0);
    idle(2);

    // 4: 33 back-to-back samples
    pop_cyc.delete();
    stalls = 0;
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < DN; i++) f[i] = DW'(fr * DN + i);
    end
    for (int i = 0; i < DN; i++) f[i] = DW'(i);
    push_exp(f, 11, 55);
    for (int i = 0; i < DN; i++) f[i] = DW'(i + 11);
    push_exp(f, 11, 176);
    for (int i = 0; i < DN; i++) f[i] = DW'(i + 22);
    push_exp(f, 11, 265);
    for (int k = 0; k < 33; k++) send(DW'(k), 1'b0);
    idle(3);
    check("t4_stalls", 64'(stalls), 64'd0);
    check("t4_frames", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check("t4_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd11);
      check("t4_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd11);
    end

    // 5: reset with a held frame and a partial frame
    o_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(5'd3, 1'b0);
    check("t5_held_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(o_valid), 64'd0);
    check("t5_rst_data",  64'(o_data),  64'd0);
    check("t5_rst_cnt",   64'(o_cnt),   64'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    o_ready = 1'b1;
    f = '0;
    f[0] = 5'd9;
    push_exp(f, 1, 9);
    send(5'd9, 1'b1);
    idle(3);

    // 6: single sample with s_last under backpressure
    o_ready = 1'b0;
    f = '0;
    f[0] = 5'd7;
    push_exp(f, 1, 7);
    send(5'd7, 1'b1);
    idle(3);
    check("t6_held_valid", 64'(o_valid), 64'd1);
    check("t6_held_cnt",   64'(o_cnt),   64'd1);
    o_ready = 1'b1;
    idle(1);
    check("t6_valid_drop", 64'(o_valid), 64'd0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
